// File: rtl/protected_pkg.sv
// Shared types and default parameters for the protection-flag guard blocks.
package protected_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRAP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int DEF_BUS_WIDTH    = 32;
  localparam int DEF_WINDOW_LOG2  = 2;
  localparam int DEF_CLEAR_CYCLES = 2;
  localparam int DEF_COUNT_WIDTH  = 8;

endpackage

// File: rtl/guard_window_cmp.sv
// Masked address comparator: hit when two addresses fall in the same
// 2^LOW_BITS-byte window.
module guard_window_cmp #(
  parameter int WIDTH    = 32,
  parameter int LOW_BITS = 2
) (
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] base,
  output logic             hit
);

  logic [WIDTH-1:0] diff;

  // Shifting the difference keeps every bit read even when LOW_BITS is 0.
  assign diff = addr ^ base;
  assign hit  = ((diff >> LOW_BITS) == '0);

endmodule

// File: rtl/protected_guard.sv
// Enforcement side of the protection flag: blocks writes into the armed
// window, traps the first fault to the CPU and pulses the setter's clear.
module protected_guard
  import protected_pkg::*;
#(
  parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int WINDOW_LOG2  = DEF_WINDOW_LOG2,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flag_in,
  input  logic [BUS_WIDTH-1:0]   addr_in,
  input  logic                   acc_valid,
  input  logic                   acc_write,
  input  logic [BUS_WIDTH-1:0]   acc_addr,
  output logic                   acc_block,
  output logic                   trap_req,
  input  logic                   trap_ack,
  output logic [BUS_WIDTH-1:0]   trap_addr,
  input  logic                   unlock,
  output logic                   flag_nreset,
  output logic [COUNT_WIDTH-1:0] violation_count,
  output logic                   busy
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t               state;
  state_t               next_state;
  logic [BUS_WIDTH-1:0] armed_addr;
  logic [CNT_W-1:0]     clr_cnt;
  logic                 clr_done;
  logic                 pending_unlock;
  logic                 hit;
  logic                 violation;

  guard_window_cmp #(
    .WIDTH    (BUS_WIDTH),
    .LOW_BITS (WINDOW_LOG2)
  ) u_cmp (
    .addr (acc_addr),
    .base (armed_addr),
    .hit  (hit)
  );

  assign violation = acc_valid & acc_write & hit & (state != IDLE);
  assign clr_done  = (clr_cnt == CNT_W'(CLEAR_CYCLES));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (flag_in) next_state = ARMED;
      ARMED: begin
        // A violation beats a same-cycle unlock; the unlock is remembered.
        if (violation)     next_state = TRAP;
        else if (unlock)   next_state = CLEAR;
        else if (!flag_in) next_state = IDLE;
      end
      TRAP:  if (trap_ack) next_state = (pending_unlock || unlock) ? CLEAR : ARMED;
      CLEAR: if (clr_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    acc_block = violation;
    trap_req  = (state == TRAP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_addr      <= '0;
      trap_addr       <= '0;
      violation_count <= '0;
      pending_unlock  <= 1'b0;
      clr_cnt         <= '0;
      flag_nreset     <= 1'b1;
    end else begin
      if (state == IDLE && flag_in)
        armed_addr <= addr_in;
      if (state == ARMED && violation)
        trap_addr <= acc_addr;
      if (violation && violation_count != COUNT_MAX)
        violation_count <= violation_count + COUNT_WIDTH'(1);

      if (state == TRAP && trap_ack)
        pending_unlock <= 1'b0;
      else if ((state == ARMED && violation && unlock) || (state == TRAP && unlock))
        pending_unlock <= 1'b1;

      clr_cnt <= (state == CLEAR) ? clr_cnt + CNT_W'(1) : '0;
      // Registered so the setter's reset line is glitch-free; it goes low the
      // cycle after CLEAR is entered and stays low for CLEAR_CYCLES cycles.
      flag_nreset <= !(state == CLEAR && next_state == CLEAR);
    end
  end

endmodule

// File: tb/tb_protected_guard.sv
// Directed bench for protected_guard: trap events are checked by a scoreboard
// monitor; bus blocking and clear-pulse timing are checked inline.
module tb_protected_guard;

  logic        clk = 1'b0;
  logic        reset;
  logic        flag_in;
  logic [31:0] addr_in;
  logic        acc_valid;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic        acc_block;
  logic        trap_req;
  logic        trap_ack;
  logic [31:0] trap_addr;
  logic        unlock;
  logic        flag_nreset;
  logic [7:0]  violation_count;
  logic        busy;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_req = 1'b0;

  protected_guard #(
    .BUS_WIDTH    (32),
    .WINDOW_LOG2  (2),
    .CLEAR_CYCLES (2),
    .COUNT_WIDTH  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flag_in         (flag_in),
    .addr_in         (addr_in),
    .acc_valid       (acc_valid),
    .acc_write       (acc_write),
    .acc_addr        (acc_addr),
    .acc_block       (acc_block),
    .trap_req        (trap_req),
    .trap_ack        (trap_ack),
    .trap_addr       (trap_addr),
    .unlock          (unlock),
    .flag_nreset     (flag_nreset),
    .violation_count (violation_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a);
    acc_valid = v;
    acc_write = w;
    acc_addr  = a;
  endtask

  // Scoreboard monitor: each rising trap_req must match the next expected fault.
  always @(negedge clk) begin
    if (trap_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_trap: trap_addr 0x%0h with nothing expected", trap_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_trap_addr", trap_addr, e.addr);
        check("sb_trap_count", 32'(violation_count), 32'(e.count));
      end
    end
    prev_req = trap_req;
  end

  initial begin
    logic [4:0] nreset_pat;
    logic [4:0] busy_pat;
    nreset_pat = 5'b11001;  // bit i = cycle i after unlock edge
    busy_pat   = 5'b00111;

    reset = 1'b1; flag_in = 1'b0; addr_in = '0; trap_ack = 1'b0; unlock = 1'b0;
    drive(0, 0, '0);
    nedge(); nedge();
    check("rst_trap_req", 32'(trap_req), 0);
    check("rst_flag_nreset", 32'(flag_nreset), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(violation_count), 0);
    check("rst_trap_addr", trap_addr, 0);
    check("rst_acc_block", 32'(acc_block), 0);
    reset = 1'b0;

    // Arming, first fault, read passthrough
    nedge(); flag_in = 1'b1; addr_in = 32'h1000; drive(1, 1, 32'h1002);
    #1 check("arm_cycle_write", 32'(acc_block), 0);
    nedge(); check("armed_busy", 32'(busy), 1); check("armed_no_trap", 32'(trap_req), 0);
    drive(1, 1, 32'h1002);
    #1 check("first_violation_block", 32'(acc_block), 1);
    exp_q.push_back('{32'h1002, 8'd1});
    nedge(); drive(1, 0, 32'h1000);
    #1 check("read_not_blocked", 32'(acc_block), 0);
    check("trap_req_up", 32'(trap_req), 1);

    // Further faults in TRAP, then ack back to ARMED
    nedge(); drive(1, 1, 32'h1001); #1 check("trap_write_1001", 32'(acc_block), 1);
    nedge(); drive(1, 1, 32'h1003); #1 check("trap_write_1003", 32'(acc_block), 1);
    nedge(); drive(0, 0, '0);
    check("count_3", 32'(violation_count), 3);
    check("first_fault_kept", trap_addr, 32'h1002);
    trap_ack = 1'b1;
    nedge(); trap_ack = 1'b0;
    check("ack_drops_req", 32'(trap_req), 0);
    check("ack_to_armed", 32'(busy), 1);
    drive(1, 1, 32'h1004); #1 check("outside_window", 32'(acc_block), 0);

    // Unlock from ARMED: flag_nreset low for exactly two cycles
    nedge(); drive(0, 0, '0); unlock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nedge(); unlock = 1'b0;
      if (i == 0) begin
        flag_in = 1'b0;
        drive(1, 1, 32'h1000);
        #1 check("clear_write_blocked", 32'(acc_block), 1);
      end else begin
        drive(0, 0, '0);
      end
      check($sformatf("clear_nreset_%0d", i), 32'(flag_nreset), 32'(nreset_pat[i]));
      check($sformatf("clear_busy_%0d", i), 32'(busy), 32'(busy_pat[i]));
    end
    nedge(); check("count_4", 32'(violation_count), 4);
    drive(1, 1, 32'h1000); #1 check("idle_not_blocked", 32'(acc_block), 0);

    // Same-cycle violation and unlock: TRAP, then straight to CLEAR, then re-arm
    nedge(); drive(0, 0, '0); flag_in = 1'b1; addr_in = 32'h2000;
    nedge(); drive(1, 1, 32'h2003); unlock = 1'b1;
    #1 check("viol_unlock_block", 32'(acc_block), 1);
    exp_q.push_back('{32'h2003, 8'd5});
    nedge(); drive(0, 0, '0); unlock = 1'b0;
    check("viol_wins_trap", 32'(trap_req), 1);
    trap_ack = 1'b1;
    nedge(); trap_ack = 1'b0;
    check("pend_req_low", 32'(trap_req), 0);
    check("pend_nreset_hi", 32'(flag_nreset), 1);
    check("pend_busy", 32'(busy), 1);
    nedge(); check("pend_nreset_lo0", 32'(flag_nreset), 0);
    nedge(); check("pend_nreset_lo1", 32'(flag_nreset), 0);
    nedge(); check("pend_idle", 32'(busy), 0); check("pend_nreset_end", 32'(flag_nreset), 1);
    addr_in = 32'h3000;
    nedge(); check("rearm_busy", 32'(busy), 1);
    drive(1, 1, 32'h2000); #1 check("old_window_free", 32'(acc_block), 0);
    nedge(); drive(1, 1, 32'h3001); #1 check("new_window_block", 32'(acc_block), 1);
    exp_q.push_back('{32'h3001, 8'd6});

    // Saturate the counter
    for (int i = 0; i < 255; i++) begin
      nedge(); drive(1, 1, 32'h3000);
    end
    nedge(); drive(0, 0, '0);
    check("count_sat", 32'(violation_count), 255);
    check("sat_trap_addr", trap_addr, 32'h3001);
    trap_ack = 1'b1;
    nedge(); trap_ack = 1'b0; drive(1, 1, 32'h3002);
    #1 check("sat_extra_block", 32'(acc_block), 1);
    exp_q.push_back('{32'h3002, 8'd255});
    nedge(); drive(0, 0, '0);
    check("sat_trap_req", 32'(trap_req), 1);
    trap_ack = 1'b1;

    // Reset during CLEAR
    nedge(); trap_ack = 1'b0; unlock = 1'b1;
    nedge(); unlock = 1'b0; flag_in = 1'b0;
    nedge(); check("pre_rst_nreset", 32'(flag_nreset), 0);
    #2 reset = 1'b1;
    #1 check("rst_clear_nreset", 32'(flag_nreset), 1);
    check("rst_clear_req", 32'(trap_req), 0);
    check("rst_clear_busy", 32'(busy), 0);
    check("rst_clear_count", 32'(violation_count), 0);
    nedge(); reset = 1'b0;

    // Reset during TRAP drops trap_req asynchronously
    nedge(); flag_in = 1'b1; addr_in = 32'h4000;
    nedge(); drive(1, 1, 32'h4000); #1 check("post_rst_block", 32'(acc_block), 1);
    exp_q.push_back('{32'h4000, 8'd1});
    nedge(); drive(0, 0, '0);
    check("post_rst_trap", 32'(trap_req), 1);
    #2 reset = 1'b1;
    #1 check("rst_trap_async", 32'(trap_req), 0);
    check("rst_trap_busy", 32'(busy), 0);
    nedge(); reset = 1'b0; flag_in = 1'b0;
    nedge(); nedge();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/protected_guard.md
# protected_guard

Enforcement side of the protection flag: it reads the sticky flag and captured address produced by the protection-flag setter. While protection is armed, it blocks bus writes that fall into the protected window and reports each first fault to the CPU over a req/ack trap handshake. On software unlock it clears the setter by driving its active-low reset for a fixed number of cycles. It sits between the setter and the data-bus write path.

## Interface
- BUS_WIDTH, 32, address width
- WINDOW_LOG2, 2, protected window is 2^WINDOW_LOG2 bytes; low address bits ignored in the compare
- CLEAR_CYCLES, 2, length of the flag-clear pulse, minimum 1
- COUNT_WIDTH, 8, width of the violation counter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- flag_in  in  1  protection flag from the setter
- addr_in  in  BUS_WIDTH  protected address from the setter
- acc_valid  in  1  bus access valid this cycle
- acc_write  in  1  access is a write
- acc_addr  in  BUS_WIDTH  access address
- acc_block  out  1  combinational; suppress this write
- trap_req  out  1  fault pending to the CPU
- trap_ack  in  1  CPU acknowledges the fault
- trap_addr  out  BUS_WIDTH  address of the first faulting write
- unlock  in  1  single-cycle request to drop protection
- flag_nreset  out  1  active-low clear for the setter
- violation_count  out  COUNT_WIDTH  saturating count of blocked writes
- busy  out  1  high in any state other than IDLE

## Operation
- States are IDLE, ARMED, TRAP and CLEAR.
- **IDLE**
  - flag_in=1 captures addr_in into armed_addr and moves to ARMED.
  - No blocking in IDLE.
- **Hit definition**
  - hit = acc_addr[BUS_WIDTH-1:WINDOW_LOG2] == armed_addr[BUS_WIDTH-1:WINDOW_LOG2].
- **Violation definition**
  - violation = acc_valid & acc_write & hit while in ARMED, TRAP or CLEAR.
  - acc_block equals violation. Reads are never blocked.
- **ARMED**
  - A violation loads trap_addr with acc_addr, increments the counter and moves to TRAP.
  - unlock moves to CLEAR.
  - flag_in=0 (external clear) moves to IDLE.
  - If a violation and unlock occur in the same cycle, the violation wins. The unlock is latched as pending_unlock.
- **TRAP**
  - trap_req=1. Further violations are blocked and counted, but trap_addr is not updated (first fault wins).
  - unlock sets pending_unlock.
  - trap_ack=1 moves to CLEAR if pending_unlock is set, otherwise to ARMED. pending_unlock is cleared on exit.
- **CLEAR**
  - flag_nreset=0 for exactly CLEAR_CYCLES cycles, then the state moves to IDLE.
  - Writes to the window stay blocked and counted throughout CLEAR.
- **Re-arm after CLEAR**
  - If flag_in is still 1 in IDLE, the block re-arms on the next edge with a fresh addr_in capture.
- **Counter**
  - Saturates at 2^COUNT_WIDTH-1. It is cleared only by reset.

## Timing
- **Reset values**
  - state IDLE; armed_addr, trap_addr and violation_count 0.
  - trap_req 0, flag_nreset 1, busy 0, pending_unlock 0.
  - acc_block 0 because the state is IDLE.
- **Reset mid-operation**
  - Returns the block to IDLE immediately. trap_req drops asynchronously and flag_nreset returns to 1.
- **Latency and handshake**
  - acc_block has zero latency, in the same cycle as the access.
  - trap_req, trap_addr and violation_count update one cycle after the violating access.
  - trap_req holds until trap_ack is sampled high and deasserts on the following edge.
  - trap_ack outside TRAP is ignored.
  - flag_nreset falls one cycle after entering CLEAR.
- **Arming window**
  - Arming takes one cycle after flag_in rises.
  - A write in the same cycle that flag_in rises is not blocked.

## Structure
- **Shared package `protected_pkg`**
  - State enum state_t with values IDLE, ARMED, TRAP, CLEAR.
  - Default parameter constants.
- **Sub-module `guard_window_cmp`**
  - Parameterised masked comparator producing hit.
  - Reused later for multi-window guards.
- **Top level**
  - Contains the FSM, capture registers, clear-pulse counter and violation counter.

## Test plan
1. Reset, then flag_in=1 with addr_in=0x1000. Write to 0x1002 → acc_block=1 that cycle; next cycle trap_req=1, trap_addr=0x1002, count=1. Read to 0x1000 → not blocked.
2. In TRAP, writes to 0x1001 then 0x1003 before the ack → both blocked, count=3, trap_addr stays 0x1002. trap_ack → trap_req low next cycle, state ARMED.
3. unlock in ARMED with CLEAR_CYCLES=2 → flag_nreset low for exactly 2 cycles. Then IDLE and busy=0. A write to 0x1000 afterwards (flag_in=0) → not blocked.
4. Same-cycle violation and unlock → TRAP. After trap_ack, the state goes directly to CLEAR.
5. Force the counter to 255 with COUNT_WIDTH=8, then one more violation → counter stays 255.
6. Assert reset during CLEAR → flag_nreset=1 and trap_req=0 immediately; state IDLE.
